// File: rtl/sknobs_store_pkg.sv
// Shared types and default widths for the key/value store: controller state
// encoding and the default key/value widths.
package sknobs_store_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int KEY_W_DFLT = 32;
  localparam int VAL_W_DFLT = 64;

endpackage

// File: rtl/sknobs_store_mem.sv
// Entry storage: DEPTH words of {key, value}, one synchronous write port
// and one combinational read port used by the linear scan.
module sknobs_store_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sknobs_store.sv
// Key/value store with linear-scan lookup. One request at a time; sets
// insert or overwrite, gets return the stored value or the caller's default.
module sknobs_store
  import sknobs_store_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int KEY_W = KEY_W_DFLT,
  parameter int VAL_W = VAL_W_DFLT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_valid,
  output logic                    set_ready,
  input  logic [KEY_W-1:0]        set_key,
  input  logic [VAL_W-1:0]        set_value,
  output logic                    set_ack,
  output logic                    set_full,
  input  logic                    get_valid,
  output logic                    get_ready,
  input  logic [KEY_W-1:0]        get_key,
  input  logic [VAL_W-1:0]        get_default,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [VAL_W-1:0]        resp_value,
  output logic                    resp_exists,
  input  logic                    clear,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = KEY_W + VAL_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_e            state_q;
  logic [CW-1:0]     count_q, idx_q;
  logic [KEY_W-1:0]  key_q;
  logic [VAL_W-1:0]  val_q, hit_val_q, resp_value_q;
  logic [AW-1:0]     hit_idx_q;
  logic              is_set_q, hit_q, miss_q;
  logic              set_ack_q, set_full_q, resp_valid_q, resp_exists_q;

  logic [EW-1:0]     rd_data;
  logic [KEY_W-1:0]  rd_key;
  logic [VAL_W-1:0]  rd_val;
  logic              scan_hit_d, scan_miss_d, set_fire, get_fire, mem_we;
  logic [AW-1:0]     mem_waddr;

  assign set_ready = (state_q == IDLE) && !clear;
  assign get_ready = set_ready && !set_valid;
  assign set_fire  = set_valid && set_ready;
  assign get_fire  = get_valid && get_ready;

  assign rd_key      = rd_data[EW-1:VAL_W];
  assign rd_val      = rd_data[VAL_W-1:0];
  // Slots at or beyond count hold stale data and must never match.
  assign scan_hit_d  = (idx_q < count_q) && (rd_key == key_q);
  assign scan_miss_d = (idx_q == count_q);

  assign mem_we    = rst_n && !clear && (state_q == WRITE) && (hit_q || (count_q != FULL_CNT));
  assign mem_waddr = hit_q ? hit_idx_q : count_q[AW-1:0];

  sknobs_store_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata ({key_q, val_q}),
    .raddr (idx_q[AW-1:0]),
    .rdata (rd_data)
  );

  // The compare result is registered, so an outcome for index i acts one
  // cycle after it is evaluated (hit i+2, miss count+2 from accept).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      set_ack_q     <= 1'b0;
      set_full_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_value_q  <= '0;
      resp_exists_q <= 1'b0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
    end else if (clear) begin
      state_q      <= IDLE;
      count_q      <= '0;
      set_ack_q    <= 1'b0;
      set_full_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      set_ack_q  <= 1'b0;
      set_full_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (set_fire || get_fire) begin
            key_q    <= set_fire ? set_key : get_key;
            val_q    <= set_fire ? set_value : get_default;
            is_set_q <= set_fire;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          if (hit_q || miss_q) begin
            if (is_set_q) begin
              state_q    <= WRITE;
              set_ack_q  <= 1'b1;
              set_full_q <= miss_q && (count_q == FULL_CNT);
            end else begin
              state_q       <= RESP;
              resp_valid_q  <= 1'b1;
              resp_value_q  <= hit_q ? hit_val_q : val_q;
              resp_exists_q <= hit_q;
            end
          end else begin
            hit_q     <= scan_hit_d;
            miss_q    <= scan_miss_d;
            hit_idx_q <= idx_q[AW-1:0];
            hit_val_q <= rd_val;
            idx_q     <= idx_q + CW'(1);
          end
        end
        WRITE: begin
          state_q <= IDLE;
          if (!hit_q && (count_q != FULL_CNT)) count_q <= count_q + CW'(1);
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign set_ack     = set_ack_q;
  assign set_full    = set_full_q;
  assign resp_valid  = resp_valid_q;
  assign resp_value  = resp_value_q;
  assign resp_exists = resp_exists_q;
  assign count       = count_q;

endmodule

// File: tb/tb_sknobs_store.sv
// Scoreboard bench for sknobs_store: the driver queues expected acks and
// responses (value, flags, arrival cycle); a monitor pops and compares them.
module tb_sknobs_store;

  localparam int DEPTH = 16;
  localparam int KEY_W = 32;
  localparam int VAL_W = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             set_valid = 1'b0, set_ready;
  logic [KEY_W-1:0] set_key = '0;
  logic [VAL_W-1:0] set_value = '0;
  logic             set_ack, set_full;
  logic             get_valid = 1'b0, get_ready;
  logic [KEY_W-1:0] get_key = '0;
  logic [VAL_W-1:0] get_default = '0;
  logic             resp_valid, resp_exists;
  logic             resp_ready = 1'b1;
  logic [VAL_W-1:0] resp_value;
  logic             clear = 1'b0;
  logic [4:0]       count;

  sknobs_store #(.DEPTH(DEPTH), .KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .set_valid(set_valid), .set_ready(set_ready), .set_key(set_key), .set_value(set_value),
    .set_ack(set_ack), .set_full(set_full),
    .get_valid(get_valid), .get_ready(get_ready), .get_key(get_key), .get_default(get_default),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_value(resp_value),
    .resp_exists(resp_exists), .clear(clear), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic full; int cyc; } set_exp_t;
  typedef struct { logic [63:0] val; logic ex; int cyc; } get_exp_t;
  set_exp_t sq[$];
  get_exp_t gq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller sits just after a negedge; returns just after the negedge that
  // follows the accept edge, with valid dropped.
  task automatic do_set(input logic [31:0] k, input logic [63:0] v, input logic full,
                        input int lat, input bit push);
    int n = 0;
    set_exp_t e;
    set_key = k; set_value = v; set_valid = 1'b1;
    #1;
    while (!set_ready && n < 100) begin @(negedge clk); #1; n++; end
    chk("set_accept", set_ready, 1);
    if (set_ready && push) begin
      e.full = full; e.cyc = cyc + 1 + lat;
      sq.push_back(e);
    end
    @(negedge clk);
    set_valid = 1'b0;
  endtask

  task automatic do_get(input logic [31:0] k, input logic [63:0] dflt, input logic ex,
                        input logic [63:0] val, input int lat, input bit push);
    int n = 0;
    get_exp_t e;
    get_key = k; get_default = dflt; get_valid = 1'b1;
    #1;
    while (!get_ready && n < 100) begin @(negedge clk); #1; n++; end
    chk("get_accept", get_ready, 1);
    if (get_ready && push) begin
      e.val = val; e.ex = ex; e.cyc = cyc + 1 + lat;
      gq.push_back(e);
    end
    @(negedge clk);
    get_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sq.size() != 0 || gq.size() != 0 || resp_valid) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) chk("drain_timeout", 64'(sq.size() + gq.size()), 0);
  endtask

  // Monitor: samples late in the low phase, after driver inputs settle.
  bit             in_resp = 1'b0;
  logic [63:0]    held_v;
  logic           held_e;
  set_exp_t       mse;
  get_exp_t       mge;

  initial begin
    forever begin
      @(negedge clk); #4;
      if (rst_n) begin
        if (set_ack) begin
          if (sq.size() == 0) chk("unexpected_set_ack", set_ack, 0);
          else begin
            mse = sq.pop_front();
            $display("set_ack full=%0d cycle=%0d", set_full, cyc);
            chk("set_full", set_full, mse.full);
            chk("set_latency", 64'(cyc), 64'(mse.cyc));
          end
        end
        if (resp_valid) begin
          if (!in_resp) begin
            if (gq.size() == 0) chk("unexpected_resp", resp_valid, 0);
            else begin
              mge = gq.pop_front();
              $display("resp value=%0h exists=%0d cycle=%0d", resp_value, resp_exists, cyc);
              chk("resp_value", resp_value, mge.val);
              chk("resp_exists", resp_exists, mge.ex);
              chk("resp_latency", 64'(cyc), 64'(mge.cyc));
            end
            held_v = resp_value; held_e = resp_exists;
          end else begin
            chk("resp_value_stable", resp_value, held_v);
            chk("resp_exists_stable", resp_exists, held_e);
          end
          in_resp = !resp_ready;
        end else begin
          in_resp = 1'b0;
        end
      end else begin
        in_resp = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_set_ack", set_ack, 0);
    chk("rst_set_full", set_full, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_value", resp_value, 0);
    chk("rst_resp_exists", resp_exists, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    #1 chk("idle_set_ready", set_ready, 1);

    // Empty store miss
    do_get(32'h1234, 64'd7, 1'b0, 64'd7, 2, 1); wait_idle();

    // Three inserts then hit at index 2
    do_set(32'hA, 64'd5, 1'b0, 2, 1);  wait_idle();
    do_set(32'hB, 64'd9, 1'b0, 3, 1);  wait_idle();
    do_set(32'hC, 64'd11, 1'b0, 4, 1); wait_idle();
    do_get(32'hC, 64'd0, 1'b1, 64'd11, 4, 1); wait_idle();
    chk("count_after_3", count, 3);

    // Overwrite existing key
    do_set(32'hB, 64'd42, 1'b0, 3, 1); wait_idle();
    chk("count_after_overwrite", count, 3);
    do_get(32'hB, 64'd0, 1'b1, 64'd42, 3, 1); wait_idle();
    do_get(32'hA, 64'd0, 1'b1, 64'd5, 2, 1);  wait_idle();

    // Fill to DEPTH, then a new key is rejected as full
    for (int j = 0; j < 13; j++) begin
      do_set(32'h100 + 32'(j), 64'h1000 + 64'(j), 1'b0, j + 5, 1); wait_idle();
    end
    chk("count_full", count, 16);
    do_set(32'hFF, 64'd1, 1'b1, 18, 1); wait_idle();
    chk("count_after_full_set", count, 16);
    do_get(32'hFF, 64'd3, 1'b0, 64'd3, 18, 1); wait_idle();
    do_get(32'h10C, 64'd0, 1'b1, 64'h100C, 17, 1); wait_idle();
    do_get(32'h101, 64'd0, 1'b1, 64'h1001, 6, 1); wait_idle();

    // Clear, then stale entries must not match
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    #1 chk("count_after_clear", count, 0);
    do_get(32'hA, 64'h55, 1'b0, 64'h55, 2, 1); wait_idle();

    // Simultaneous set/get: set wins, response held under backpressure
    get_key = 32'h1; get_default = 64'd0; get_valid = 1'b1; resp_ready = 1'b0;
    set_key = 32'h1; set_value = 64'd2; set_valid = 1'b1;
    #1;
    chk("both_set_ready", set_ready, 1);
    chk("both_get_ready", get_ready, 0);
    do_set(32'h1, 64'd2, 1'b0, 2, 1);
    do_get(32'h1, 64'd0, 1'b1, 64'd2, 2, 1);
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    chk("resp_seen", resp_valid, 1);
    repeat (5) @(negedge clk);
    resp_ready = 1'b1;
    wait_idle();
    do_get(32'hB, 64'h66, 1'b0, 64'h66, 3, 1); wait_idle();

    // Clear while a get is scanning: no response, back to idle
    do_get(32'h999, 64'd1, 1'b0, 64'd0, 0, 0);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    #1;
    chk("clear_scan_count", count, 0);
    chk("clear_scan_get_ready", get_ready, 1);
    repeat (6) @(negedge clk);

    // Reset in the middle of a set: dropped silently
    do_set(32'h5, 64'd5, 1'b0, 2, 1); wait_idle();
    chk("count_before_reset", count, 1);
    do_set(32'h6, 64'd6, 1'b0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1 chk("reset_mid_set_count", count, 0);
    repeat (6) @(negedge clk);
    chk("reset_mid_set_count_later", count, 0);
    chk("reset_mid_set_no_ack", set_ack, 0);

    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
